// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Decode-stage data-hazard detector for a pipelined MIPS core. It keeps a
//   private shift-register scoreboard of the destination registers of
//   instructions already issued past decode. From that scoreboard it derives:
//   the IF/ID hold, the ID/EX bubble, the EX operand forwarding selects and a
//   saturating count of stalled cycles.
//
//   Scoreboard entry k: k = 0 is EX, 1 is MEM, 2 is WB, and so on.
//
//   Handshake: there is no valid/ready pair. id_valid qualifies id_instr. An
//   instruction leaves decode on a clock edge where id_valid = 1 and
//   stall = 0. While stall = 1, upstream must hold id_instr and id_valid.
//
// Parameters
//   NUM_STAGES  tracked stages after decode (1..8)
//   FORWARD_EN  1: bypass network present, stall only on load-use
//               0: stall on any RAW match
//   CNT_W       stall counter width
//   SEL_W       forwarding select width, 2**SEL_W >= NUM_STAGES+1
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   id_valid, id_instr     instruction currently in decode
//   stall                  hold PC and IF/ID this cycle
//   bubble                 insert NOP into ID/EX this cycle (same as stall)
//   fwd_a_sel, fwd_b_sel   rs / rt source: 0 = register file, k+1 = entry k
//   stall_count            saturating count of stalled cycles
module hazard_scoreboard #(
  parameter int NUM_STAGES = 3,
  parameter int FORWARD_EN = 1,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  output logic             stall,
  output logic             bubble,
  output logic [SEL_W-1:0] fwd_a_sel,
  output logic [SEL_W-1:0] fwd_b_sel,
  output logic [CNT_W-1:0] stall_count
);

  // Scoreboard storage, one bit or field per in-flight stage.
  logic [NUM_STAGES-1:0]      sb_valid;
  logic [NUM_STAGES-1:0][4:0] sb_dest;
  logic [NUM_STAGES-1:0]      sb_load;

  // Decoded view of id_instr.
  logic [5:0] opcode;
  logic [4:0] rs, rt, rd;
  logic       reads_rs, reads_rt, writes, is_load;
  logic [4:0] dest;
  logic [4:0] src_a, src_b;

  // The immediate and funct bits play no part in hazard detection.
  logic unused_bits;
  assign unused_bits = ^id_instr[10:0];

  assign opcode = id_instr[31:26];
  assign rs     = id_instr[25:21];
  assign rt     = id_instr[20:16];
  assign rd     = id_instr[15:11];

  always_comb begin
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    writes   = 1'b0;
    is_load  = 1'b0;
    dest     = 5'd0;
    // An all-zero word is the canonical NOP (sll $0,$0,0) and touches nothing.
    if (id_instr != 32'd0) begin
      case (opcode)
        6'h00: begin
          reads_rs = 1'b1;
          reads_rt = 1'b1;
          writes   = 1'b1;
          dest     = rd;
        end
        6'h04, 6'h05, 6'h2B: begin
          reads_rs = 1'b1;
          reads_rt = 1'b1;
        end
        6'h23: begin
          reads_rs = 1'b1;
          writes   = 1'b1;
          dest     = rt;
          is_load  = 1'b1;
        end
        6'h08, 6'h0A, 6'h0C, 6'h0D: begin
          reads_rs = 1'b1;
          writes   = 1'b1;
          dest     = rt;
        end
        default: ;
      endcase
    end
  end

  // An unread source is folded to $0, which can never match.
  assign src_a = reads_rs ? rs : 5'd0;
  assign src_b = reads_rt ? rt : 5'd0;

  logic [NUM_STAGES-1:0] match_a, match_b;
  logic [SEL_W-1:0]      sel_a_raw, sel_b_raw;
  logic                  load_use, raw_stall, active;

  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      match_a[k] = sb_valid[k] && (sb_dest[k] == src_a) && (src_a != 5'd0);
      match_b[k] = sb_valid[k] && (sb_dest[k] == src_b) && (src_b != 5'd0);
    end
  end

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    sel_a_raw = '0;
    sel_b_raw = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (match_a[k]) sel_a_raw = SEL_W'(k + 1);
      if (match_b[k]) sel_b_raw = SEL_W'(k + 1);
    end
  end

  // With forwarding, only a load still in EX cannot be bypassed in time.
  assign load_use  = sb_valid[0] && sb_load[0] && (match_a[0] || match_b[0]);
  assign raw_stall = (FORWARD_EN != 0) ? load_use : (|{match_a, match_b});
  // Reset aborts a stall in the same cycle.
  assign active    = id_valid && !rst;

  always_comb begin
    stall     = active && raw_stall;
    bubble    = stall;
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    if ((FORWARD_EN != 0) && active && !raw_stall) begin
      fwd_a_sel = sel_a_raw;
      fwd_b_sel = sel_b_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_valid    <= '0;
      sb_dest     <= '0;
      sb_load     <= '0;
      stall_count <= '0;
    end else begin
      // A stalled or absent instruction enters EX as an invalid bubble.
      // A write to $0 is recorded as invalid, so it never causes a hazard.
      sb_valid[0] <= id_valid && !stall && writes && (dest != 5'd0);
      sb_dest[0]  <= dest;
      sb_load[0]  <= is_load;
      for (int k = 1; k < NUM_STAGES; k++) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_dest[k]  <= sb_dest[k-1];
        sb_load[k]  <= sb_load[k-1];
      end
      if (stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
